reg_wb_arbiter: RTL and testbench
=================================

Name: reg_wb_arbiter

Overview:
- Sequences and shares the single register-file write port (w_reg/w_data/RegWrite) among three writeback requesters.
  - Debug/loader port: fixed highest priority.
  - ALU-result port and memory-load port: round-robin between the two.
- After reset, optionally runs a clear sequence that zeroes X0..X30 before any requester is served.
- Sits between the EX/MEM writeback sources and the register file in the ID stage. Outputs are registered, so the register file sees clean one-cycle write strobes.

Parameters:
- WORD, 64, data width of the register file and of every requester data bus.
- INIT_CLEAR, 1, 1 = run the zero-clear sequence after reset; 0 = enter RUN directly.
- ZR_IDX, 31, register index hard-wired to zero (XZR); writes to it are accepted but never issued.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- dbg_valid  input  1  debug write request
- dbg_reg  input  5  debug destination register
- dbg_data  input  WORD  debug write data
- dbg_ready  output  1  debug request accepted this cycle
- alu_valid  input  1  ALU writeback request
- alu_reg  input  5  ALU destination register
- alu_data  input  WORD  ALU write data
- alu_ready  output  1  ALU request accepted this cycle
- mem_valid  input  1  load writeback request
- mem_reg  input  5  load destination register
- mem_data  input  WORD  load write data
- mem_ready  output  1  load request accepted this cycle
- RegWrite  output  1  register-file write strobe
- w_reg  output  5  register-file write index
- w_data  output  WORD  register-file write data
- init_done  output  1  high once in RUN state

Behaviour:
- Reset is rst_n, asynchronous, active-low; clock is clk.
- Reset values:
  - RegWrite=0, w_reg=0, w_data=0, init_done=0.
  - RR pointer: last_grant=MEM, so ALU wins the first tie.
  - State = CLEAR when INIT_CLEAR=1, otherwise RUN.
  - Clear counter = 0.
- FSM states: CLEAR and RUN.
  - CLEAR: every edge registers RegWrite=1, w_reg=cnt, w_data=0, then cnt++.
  - When cnt==30 has been issued, next state is RUN. CLEAR lasts exactly 31 cycles.
  - In CLEAR all *_ready=0 and init_done=0.
  - RUN: init_done=1. There is no return to CLEAR except via reset.
- Arbitration (RUN only, combinational readies):
  - dbg_valid=1 -> dbg_ready=1; alu_ready=mem_ready=0.
  - Else only one of alu_valid/mem_valid is high -> that port's ready=1.
  - Else both high -> grant the port that is not last_grant.
  - A ready is never asserted without the matching valid.
  - At most one ready is high per cycle.
  - A handshake is valid & ready in the same cycle.
- RR pointer: updated to ALU or MEM only on an ALU or MEM handshake. A dbg handshake leaves it unchanged.
- Latency:
  - A handshake at edge t drives w_reg/w_data on the outputs after edge t.
  - RegWrite=1 for exactly that one cycle, so the register-file write lands at edge t+1.
  - One write per cycle; back-to-back handshakes give a continuous RegWrite.
- No handshake in a cycle -> RegWrite=0 next cycle. w_reg/w_data hold their last value.
- Zero register:
  - A handshake with reg==ZR_IDX completes: ready=1, and the RR pointer updates for ALU/MEM.
  - The next cycle has RegWrite=0; w_reg/w_data are not updated.
- Requester contract: valid, reg and data stay stable until ready. The block does not buffer; a request dropped without a handshake is lost.
- Reset mid-operation:
  - Outputs, counter and pointer return to reset values immediately.
  - A pending output write is cancelled (RegWrite=0 asynchronously).
  - CLEAR restarts from X0.
- The block does no width arithmetic beyond the 5-bit counter; data passes through unchanged at WORD bits.

Test Plan:
- Clear sequence: INIT_CLEAR=1, release reset, hold all valids high -> RegWrite=1 for 31 cycles with w_reg=0..30 and w_data=0. All readies stay 0 throughout. init_done rises on cycle 31, and the first grant goes to dbg.
- Single ALU write: RUN, alu_valid=1, alu_reg=5, alu_data=0x1234 for one cycle -> alu_ready=1 that cycle. Next cycle RegWrite=1, w_reg=5, w_data=0x1234. The cycle after, RegWrite=0.
- Round-robin: alu_valid and mem_valid both held high for 4 cycles, distinct regs 1/2 -> grants alternate ALU, MEM, ALU, MEM. RegWrite stays high for 4 consecutive cycles with w_reg 1,2,1,2.
- Debug priority: all three valid, dbg_reg=7, for 2 cycles, then dbg drops -> dbg granted twice. Next grant is ALU because the pointer was unchanged from reset.
- XZR drop: mem_valid=1, mem_reg=31, mem_data=0xFFFF -> mem_ready=1, next cycle RegWrite=0, and w_reg/w_data keep their previous values.
- Reset mid-clear: assert rst_n=0 when w_reg=12 during CLEAR -> RegWrite=0 and w_reg=0 immediately. After release, the clear restarts at w_reg=0 and runs the full 31 cycles.

Source files
------------

// File: rtl/reg_wb_arbiter.sv
// rtl/reg_wb_arbiter.sv - register-file write-port arbiter with post-reset clear sequence
module reg_wb_arbiter #(
    parameter int WORD       = 64,
    parameter int INIT_CLEAR = 1,
    parameter int ZR_IDX     = 31
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            dbg_valid,
    input  logic [4:0]      dbg_reg,
    input  logic [WORD-1:0] dbg_data,
    output logic            dbg_ready,
    input  logic            alu_valid,
    input  logic [4:0]      alu_reg,
    input  logic [WORD-1:0] alu_data,
    output logic            alu_ready,
    input  logic            mem_valid,
    input  logic [4:0]      mem_reg,
    input  logic [WORD-1:0] mem_data,
    output logic            mem_ready,
    output logic            RegWrite,
    output logic [4:0]      w_reg,
    output logic [WORD-1:0] w_data,
    output logic            init_done
);

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;
    localparam logic       LG_ALU   = 1'b0;
    localparam logic       LG_MEM   = 1'b1;
    localparam logic [4:0] ZR       = ZR_IDX[4:0];
    localparam logic [4:0] LAST_CLR = 5'd30;
    localparam logic [0:0] ST_RESET = (INIT_CLEAR != 0) ? ST_CLEAR : ST_RUN;

    logic [0:0]      state;
    logic [4:0]      cnt;
    logic            last_grant;
    logic            run;
    logic            grant_dbg;
    logic            grant_alu;
    logic            grant_mem;
    logic            handshake;
    logic [4:0]      sel_reg;
    logic [WORD-1:0] sel_data;

    assign run = (state == ST_RUN);

    // Debug always wins; on an ALU/MEM tie the port not granted last goes next.
    always_comb begin
        grant_dbg = run && dbg_valid;
        grant_alu = run && !dbg_valid && alu_valid && (!mem_valid || last_grant == LG_MEM);
        grant_mem = run && !dbg_valid && mem_valid && (!alu_valid || last_grant == LG_ALU);
        handshake = grant_dbg || grant_alu || grant_mem;
        sel_reg   = '0;
        sel_data  = '0;
        if (grant_dbg) begin
            sel_reg  = dbg_reg;
            sel_data = dbg_data;
        end else if (grant_alu) begin
            sel_reg  = alu_reg;
            sel_data = alu_data;
        end else if (grant_mem) begin
            sel_reg  = mem_reg;
            sel_data = mem_data;
        end
    end

    assign dbg_ready = grant_dbg;
    assign alu_ready = grant_alu;
    assign mem_ready = grant_mem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_RESET;
            cnt        <= '0;
            last_grant <= LG_MEM;
            RegWrite   <= 1'b0;
            w_reg      <= '0;
            w_data     <= '0;
            init_done  <= 1'b0;
        end else if (state == ST_CLEAR) begin
            RegWrite  <= 1'b1;
            w_reg     <= cnt;
            w_data    <= '0;
            cnt       <= cnt + 5'd1;
            if (cnt == LAST_CLR) begin
                state     <= ST_RUN;
                init_done <= 1'b1;
            end
        end else begin
            init_done <= 1'b1;
            // XZR writes complete the handshake but never reach the register file.
            if (handshake && sel_reg != ZR) begin
                RegWrite <= 1'b1;
                w_reg    <= sel_reg;
                w_data   <= sel_data;
            end else begin
                RegWrite <= 1'b0;
            end
            if (grant_alu) last_grant <= LG_ALU;
            if (grant_mem) last_grant <= LG_MEM;
        end
    end

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// tb/tb_reg_wb_arbiter.sv - randomized scoreboard bench for reg_wb_arbiter
module tb_reg_wb_arbiter;

    localparam int WORD   = 64;
    localparam int G_NONE = -1;
    localparam int G_DBG  = 0;
    localparam int G_ALU  = 1;
    localparam int G_MEM  = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            dbg_valid = 1'b0, alu_valid = 1'b0, mem_valid = 1'b0;
    logic [4:0]      dbg_reg = '0, alu_reg = '0, mem_reg = '0;
    logic [WORD-1:0] dbg_data = '0, alu_data = '0, mem_data = '0;
    logic            dbg_ready, alu_ready, mem_ready;
    logic            RegWrite, init_done;
    logic [4:0]      w_reg;
    logic [WORD-1:0] w_data;

    reg_wb_arbiter #(.WORD(WORD), .INIT_CLEAR(1), .ZR_IDX(31)) dut (
        .clk(clk), .rst_n(rst_n),
        .dbg_valid(dbg_valid), .dbg_reg(dbg_reg), .dbg_data(dbg_data), .dbg_ready(dbg_ready),
        .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_reg(mem_reg), .mem_data(mem_data), .mem_ready(mem_ready),
        .RegWrite(RegWrite), .w_reg(w_reg), .w_data(w_data), .init_done(init_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int              t;
        logic [4:0]      r;
        logic [WORD-1:0] d;
    } wr_t;

    wr_t             exp_q[$];
    int              checks = 0;
    int              failures = 0;
    int              edges = 0;
    bit              alu_next = 1'b1;
    logic [4:0]      hold_reg;
    logic [WORD-1:0] hold_data;
    int              g;
    logic            pv[3];
    logic [4:0]      pr[3];
    logic [WORD-1:0] pd[3];

    task automatic chk(input string name, input logic [WORD-1:0] act, input logic [WORD-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (edge %0d)", name, act, exp, edges);
        end
    endtask

    // Monitor: every RegWrite pulse must match the oldest expected write, on its cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_reg  = '0;
            hold_data = '0;
        end else if (RegWrite) begin
            if (exp_q.size() == 0) begin
                chk("spurious_write", {59'd0, w_reg}, 64'h0);
                chk("spurious_strobe", 64'(RegWrite), 64'h0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("write_cycle", 64'(edges), 64'(e.t));
                chk("w_reg", {59'd0, w_reg}, {59'd0, e.r});
                chk("w_data", w_data, e.d);
                hold_reg  = e.r;
                hold_data = e.d;
            end
        end else begin
            if (exp_q.size() != 0 && exp_q[0].t <= edges) begin
                chk("missed_write", 64'(RegWrite), 64'h1);
                void'(exp_q.pop_front());
            end
            chk("hold_w_reg", {59'd0, w_reg}, {59'd0, hold_reg});
            chk("hold_w_data", w_data, hold_data);
        end
    end

    // One clock of stimulus; the reference model predicts grants and pushes expected writes.
    task automatic cycle(input logic dv, input logic [4:0] dr, input logic [WORD-1:0] dd,
                         input logic av, input logic [4:0] ar, input logic [WORD-1:0] ad,
                         input logic mv, input logic [4:0] mr, input logic [WORD-1:0] md,
                         output int gr);
        logic [4:0] r;
        logic [WORD-1:0] d;
        wr_t e;
        dbg_valid = dv; dbg_reg = dr; dbg_data = dd;
        alu_valid = av; alu_reg = ar; alu_data = ad;
        mem_valid = mv; mem_reg = mr; mem_data = md;
        @(negedge clk);
        gr = G_NONE;
        if (edges >= 31) begin
            if (dv)            gr = G_DBG;
            else if (av && mv) gr = alu_next ? G_ALU : G_MEM;
            else if (av)       gr = G_ALU;
            else if (mv)       gr = G_MEM;
        end
        chk("readies", {61'd0, dbg_ready, alu_ready, mem_ready},
            {61'd0, gr == G_DBG, gr == G_ALU, gr == G_MEM});
        chk("init_done", 64'(init_done), 64'(edges >= 31));
        if (edges < 31) begin
            e.t = edges + 1; e.r = 5'(edges); e.d = '0;
            exp_q.push_back(e);
        end else if (gr != G_NONE) begin
            r = (gr == G_DBG) ? dr : (gr == G_ALU) ? ar : mr;
            d = (gr == G_DBG) ? dd : (gr == G_ALU) ? ad : md;
            if (r != 5'd31) begin
                e.t = edges + 1; e.r = r; e.d = d;
                exp_q.push_back(e);
            end
        end
        if (gr == G_ALU) alu_next = 1'b0;
        if (gr == G_MEM) alu_next = 1'b1;
        @(posedge clk);
        #1;
        edges++;
    endtask

    task automatic idle(input int n);
        int gg;
        for (int i = 0; i < n; i++)
            cycle(0, 5'd0, '0, 0, 5'd0, '0, 0, 5'd0, '0, gg);
    endtask

    task automatic do_reset();
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_RegWrite", 64'(RegWrite), 64'h0);
        chk("rst_w_reg", {59'd0, w_reg}, 64'h0);
        chk("rst_w_data", w_data, 64'h0);
        chk("rst_init_done", 64'(init_done), 64'h0);
        exp_q.delete();
        alu_next = 1'b1;
        dbg_valid = 0; alu_valid = 0; mem_valid = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        edges = 0;
    endtask

    initial begin
        @(posedge clk);
        do_reset();
        // Clear with all requesters pending, then debug priority and round-robin.
        for (int i = 0; i < 33; i++)
            cycle(1, 5'd7, 64'hD0D0, 1, 5'd1, 64'hA1, 1, 5'd2, 64'hB2, g);
        for (int i = 0; i < 4; i++)
            cycle(0, 5'd0, '0, 1, 5'd1, 64'hA1 + 64'(i), 1, 5'd2, 64'hB2 + 64'(i), g);
        idle(1);
        cycle(0, 5'd0, '0, 1, 5'd5, 64'h1234, 0, 5'd0, '0, g);
        idle(1);
        cycle(0, 5'd0, '0, 0, 5'd0, '0, 1, 5'd31, 64'hFFFF, g);
        idle(2);
        // Reset while the clear sequence is showing w_reg=12.
        do_reset();
        while (edges < 13) idle(1);
        do_reset();
        idle(34);
        for (int p = 0; p < 3; p++) pv[p] = 1'b0;
        for (int i = 0; i < 400; i++) begin
            for (int p = 0; p < 3; p++) begin
                if (!pv[p] && $urandom_range(0, (p == 0) ? 5 : 1) == 0) begin
                    pv[p] = 1'b1;
                    pr[p] = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 30));
                    pd[p] = {$urandom, $urandom};
                end
            end
            cycle(pv[0], pr[0], pd[0], pv[1], pr[1], pd[1], pv[2], pr[2], pd[2], g);
            if (g != G_NONE) pv[g] = 1'b0;
        end
        idle(3);
        chk("queue_drained", 64'(exp_q.size()), 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
